midi_rx_framer: RTL and testbench

- Parametrised MIDI serial receiver and message assembler.
- Replaces the fixed shift-register sampler with a proper receive path: start-bit validation, mid-bit sampling, stop-bit check and byte strobe.
- Parses bytes into complete channel messages (status plus 1 or 2 data bytes) for the playback logic.
- Sits between the `usart` input pin and the LED/playback datapath in the top level.

---
 rtl/midi_rx_framer.sv | 193 +++++++++++++++++++
 tb/tb_midi_rx_framer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_rx_framer.sv
// MIDI UART receiver plus channel-message assembler.
// Define MIDI_RX_RUNNING_STATUS_EN to keep status across messages.
module midi_rx_framer #(
  parameter int CLKS_PER_BIT = 1600,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [7:0] msg_status,
  output logic [7:0] msg_data1,
  output logic [7:0] msg_data2,
  output logic       msg_valid,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2-1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT-1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [3:0]    LAST = 4'(DATA_BITS-1);

`ifdef MIDI_RX_RUNNING_STATUS_EN
  localparam logic RS_EN = 1'b1;
`else
  localparam logic RS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BRK
  } state_t;

  state_t state, state_n;

  logic rx_s1, rx_s2;
  logic [CW-1:0] cnt;
  logic [3:0] bit_idx;
  logic [DATA_BITS-1:0] shreg;

  logic half_hit, full_hit, last_bit;
  logic cnt_clr, bit_clr, take_bit;
  logic stop_ok, stop_bad;

  assign half_hit = (cnt == HALF);
  assign full_hit = (cnt == FULL);
  assign last_bit = (bit_idx == LAST);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (!rx_s2) state_n = START;
      START: if (half_hit)
               state_n = rx_s2 ? IDLE : DATA;
      DATA:  if (full_hit && last_bit)
               state_n = STOP;
      STOP:  if (full_hit)
               state_n = rx_s2 ? IDLE : BRK;
      BRK:   if (rx_s2) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr  = 1'b0;
    bit_clr  = 1'b0;
    take_bit = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    unique case (state)
      IDLE:  cnt_clr = 1'b1;
      START: begin
        cnt_clr = half_hit;
        bit_clr = 1'b1;
      end
      DATA: begin
        cnt_clr  = full_hit;
        take_bit = full_hit;
      end
      STOP: begin
        cnt_clr  = full_hit;
        stop_ok  = full_hit & rx_s2;
        stop_bad = full_hit & ~rx_s2;
      end
      BRK:     cnt_clr = 1'b1;
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= stop_ok;
      frame_err <= stop_bad;
      cnt <= cnt_clr ? '0 : cnt + ONE;
      if (bit_clr)
        bit_idx <= '0;
      else if (take_bit)
        bit_idx <= bit_idx + 4'd1;
      // LSB arrives first, so shift toward bit 0
      if (take_bit)
        shreg <= {rx_s2, shreg[DATA_BITS-1:1]};
      if (stop_ok)
        rx_byte <= 8'(shreg);
    end
  end

  logic       have_st, need2, dcnt;
  logic [7:0] st_q, d1_q;
  logic       is_rt, is_sys, is_stat, is_dat;

  assign is_rt   = (rx_byte[7:3] == 5'b11111);
  assign is_sys  = (rx_byte[7:3] == 5'b11110);
  assign is_dat  = ~rx_byte[7];
  assign is_stat = rx_byte[7] & (rx_byte[7:4] != 4'hF);

  always_ff @(posedge clk) begin
    if (rst) begin
      have_st    <= 1'b0;
      need2      <= 1'b0;
      dcnt       <= 1'b0;
      st_q       <= '0;
      d1_q       <= '0;
      msg_status <= '0;
      msg_data1  <= '0;
      msg_data2  <= '0;
      msg_valid  <= 1'b0;
    end else begin
      msg_valid <= 1'b0;
      if (frame_err) begin
        dcnt    <= 1'b0;
        have_st <= have_st & RS_EN;
      end else if (rx_valid) begin
        unique case (1'b1)
          is_rt: begin
          end
          is_sys: begin
            have_st <= 1'b0;
            dcnt    <= 1'b0;
          end
          is_stat: begin
            st_q    <= rx_byte;
            have_st <= 1'b1;
            need2   <= (rx_byte[7:5] != 3'b110);
            dcnt    <= 1'b0;
          end
          is_dat: begin
            if (have_st) begin
              if (!need2 || dcnt) begin
                msg_status <= st_q;
                msg_data1  <= need2 ? d1_q : rx_byte;
                msg_data2  <= need2 ? rx_byte : 8'h00;
                msg_valid  <= 1'b1;
                dcnt       <= 1'b0;
                have_st    <= RS_EN;
              end else begin
                d1_q <= rx_byte;
                dcnt <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_midi_rx_framer.sv
// Randomised bench for midi_rx_framer with a byte-level message model.
// Build with MIDI_RX_RUNNING_STATUS_EN to check the running-status variant.
module tb_midi_rx_framer;

  localparam int C   = 16;
  localparam int LAT = 2 + C/2 + 9*C;
`ifdef MIDI_RX_RUNNING_STATUS_EN
  localparam bit RS = 1'b1;
`else
  localparam bit RS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, rx;
  logic [7:0] rx_byte, msg_status, msg_data1, msg_data2;
  logic rx_valid, frame_err, msg_valid, busy;

  always #5 clk = ~clk;

  midi_rx_framer #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .frame_err(frame_err), .msg_status(msg_status),
    .msg_data1(msg_data1), .msg_data2(msg_data2),
    .msg_valid(msg_valid), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fall_cyc = -100000;
  int n_rxv = 0, n_msg = 0, n_ferr = 0;

  logic [8:0]  evq[$];
  logic [23:0] msgq[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Byte-level reference: what each received byte means to the assembler
  bit         m_have;
  logic [7:0] m_st;
  int         m_cnt;
  logic [7:0] m_d [2];

  task automatic model_reset();
    m_have = 1'b0;
    m_cnt  = 0;
    m_st   = 8'h00;
  endtask

  task automatic model_rx(input logic [7:0] b);
    int need;
    evq.push_back({1'b0, b});
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin
      m_have = 1'b0;
      m_cnt  = 0;
    end else if (b >= 8'h80) begin
      m_st   = b;
      m_have = 1'b1;
      m_cnt  = 0;
    end else if (m_have) begin
      need = (m_st >= 8'hC0 && m_st <= 8'hDF) ? 1 : 2;
      m_d[m_cnt] = b;
      m_cnt++;
      if (m_cnt == need) begin
        msgq.push_back({m_st, m_d[0],
                        (need == 2) ? m_d[1] : 8'h00});
        m_cnt  = 0;
        m_have = RS;
      end
    end
  endtask

  task automatic model_ferr();
    evq.push_back(9'h100);
    m_cnt = 0;
    if (!RS) m_have = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_d = 1'b1;
  logic       prev_rxv = 1'b0;
  logic [7:0] cmp_last = 8'h00;
  logic [23:0] cmp_msg = 24'h0;

  always @(negedge clk) begin
    logic [8:0]  e;
    logic [23:0] m;
    if (rst) begin
      if (rst_d)
        chk("reset_outputs",
            {rx_byte, rx_valid, frame_err, msg_status,
             msg_data1, msg_data2, msg_valid, busy}, 0);
      prev_rxv = 1'b0;
      cmp_last = 8'h00;
      cmp_msg  = 24'h0;
    end else begin
      if (rx_valid || frame_err)
        chk("strobe_excl", {31'd0, rx_valid & frame_err}, 0);
      if (rx_valid) begin
        n_rxv++;
        if (evq.size() == 0) chk("rx_unexpected", 1, 0);
        else begin
          e = evq.pop_front();
          chk("rx_kind", {31'd0, e[8]}, 0);
          chk("rx_byte", {24'd0, rx_byte}, {24'd0, e[7:0]});
          chk("rx_latency", cyc - fall_cyc, LAT);
          cmp_last = e[7:0];
        end
      end else begin
        chk("rx_hold", {24'd0, rx_byte}, {24'd0, cmp_last});
      end
      if (frame_err) begin
        n_ferr++;
        if (evq.size() == 0) chk("ferr_unexpected", 1, 0);
        else begin
          e = evq.pop_front();
          chk("ferr_kind", {31'd0, e[8]}, 1);
          chk("ferr_latency", cyc - fall_cyc, LAT);
        end
      end
      if (msg_valid) begin
        n_msg++;
        chk("msg_timing", {31'd0, prev_rxv}, 1);
        if (msgq.size() == 0) chk("msg_unexpected", 1, 0);
        else begin
          m = msgq.pop_front();
          chk("msg_fields",
              {8'd0, msg_status, msg_data1, msg_data2},
              {8'd0, m});
          cmp_msg = m;
        end
      end else begin
        chk("msg_hold",
            {8'd0, msg_status, msg_data1, msg_data2},
            {8'd0, cmp_msg});
      end
      prev_rxv = rx_valid;
    end
    rst_d = rst;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic [7:0] b,
                             input bit ok,
                             input int lowc);
    fall_cyc = cyc + 1;
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(C);
    end
    if (ok) begin
      rx = 1'b1;
      tick(C);
    end else begin
      rx = 1'b0;
      tick(lowc);
      rx = 1'b1;
      tick(C);
    end
  endtask

  task automatic send(input logic [7:0] b);
    model_rx(b);
    drive_frame(b, 1'b1, 0);
  endtask

  task automatic send_err(input logic [7:0] b, input int lowc);
    model_ferr();
    drive_frame(b, 1'b0, lowc);
  endtask

  int a_rx, a_msg, a_fe;

  task automatic snap();
    a_rx  = n_rxv;
    a_msg = n_msg;
    a_fe  = n_ferr;
  endtask

  initial begin
    int r;
    logic [7:0] b;
    rst = 1'b1;
    rx  = 1'b1;
    model_reset();
    tick(4);
    rst = 1'b0;
    tick(3);
    chk("idle_busy", {31'd0, busy}, 0);

    snap();
    send(8'h90); send(8'h3C); send(8'h64);
    tick(5);
    chk("t1_rxcount", n_rxv - a_rx, 3);
    chk("t1_msgcount", n_msg - a_msg, 1);
    chk("t1_ferr", n_ferr - a_fe, 0);
    chk("t1_msg", {8'd0, msg_status, msg_data1, msg_data2},
        32'h00903C64);

    snap();
    send(8'h3E); send(8'h00);
    tick(5);
    chk("t2_rxcount", n_rxv - a_rx, 2);
`ifdef MIDI_RX_RUNNING_STATUS_EN
    chk("t2_msgcount", n_msg - a_msg, 1);
    chk("t2_msg", {8'd0, msg_status, msg_data1, msg_data2},
        32'h00903E00);
`else
    chk("t2_msgcount", n_msg - a_msg, 0);
`endif

    snap();
    send(8'hC5); send(8'h07);
    tick(5);
    chk("t3_msgcount", n_msg - a_msg, 1);
    chk("t3_msg", {8'd0, msg_status, msg_data1, msg_data2},
        32'h00C50700);

    snap();
    send(8'h90); send(8'hF8); send(8'h3C); send(8'h64);
    tick(5);
    chk("t4_rxcount", n_rxv - a_rx, 4);
    chk("t4_msgcount", n_msg - a_msg, 1);
    chk("t4_msg", {8'd0, msg_status, msg_data1, msg_data2},
        32'h00903C64);

    snap();
    rx = 1'b0;
    tick(5);
    chk("glitch_busy_hi", {31'd0, busy}, 1);
    rx = 1'b1;
    tick(20);
    chk("glitch_busy_lo", {31'd0, busy}, 0);
    chk("glitch_rx", n_rxv - a_rx, 0);
    chk("glitch_ferr", n_ferr - a_fe, 0);

    snap();
    send_err(8'h55, 40);
    tick(5);
    chk("t6_ferr", n_ferr - a_fe, 1);
    chk("t6_rxbyte_kept", {24'd0, rx_byte}, 32'h64);
    send(8'h80);
    tick(5);
    chk("t6_rxbyte_new", {24'd0, rx_byte}, 32'h80);
    chk("t6_rxcount", n_rxv - a_rx, 1);

    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      if (r < 5)       b = 8'($urandom_range(0, 127));
      else if (r < 8)  b = 8'($urandom_range(128, 239));
      else if (r == 8) b = 8'($urandom_range(240, 247));
      else             b = 8'($urandom_range(248, 255));
      if ($urandom_range(0, 11) == 0)
        send_err(b, $urandom_range(C, 3*C));
      else
        send(b);
      tick($urandom_range(0, 12));
    end
    tick(20);
    chk("evq_drained", evq.size(), 0);
    chk("msgq_drained", msgq.size(), 0);

    snap();
    fork
      drive_frame(8'hAA, 1'b1, 0);
    join_none
    tick(60);
    rst = 1'b1;
    wait fork;
    tick(3);
    chk("abort_rx", n_rxv - a_rx, 0);
    chk("abort_ferr", n_ferr - a_fe, 0);
    chk("abort_zero",
        {rx_byte, rx_valid, frame_err, msg_status,
         msg_data1, msg_data2, msg_valid, busy}, 0);
    rst = 1'b0;
    model_reset();
    tick(5);

    snap();
    send(8'hC5); send(8'h07);
    tick(5);
    chk("recover_msg", {8'd0, msg_status, msg_data1, msg_data2},
        32'h00C50700);
    chk("recover_count", n_msg - a_msg, 1);
    chk("final_empty", evq.size() + msgq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
